// File: rtl/lhr_repair_unit_pkg.sv
// Shared definitions for the local-history repair unit: repair FSM states and
// default geometry of the local history table and checkpoint queue.
package lhr_repair_unit_pkg;

    localparam int LHR_M_DEFAULT     = 6;
    localparam int LHR_K_DEFAULT     = 10;
    localparam int LHR_DEPTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_FIX  = 2'd2
    } repair_state_t;

endpackage

// File: rtl/lhr_ckpt_fifo.sv
// Checkpoint queue: in-order push/pop of (index, pre-update LHR, predicted
// direction) plus a random read port used while walking back over entries.
module lhr_ckpt_fifo
    import lhr_repair_unit_pkg::*;
#(
    parameter int M     = LHR_M_DEFAULT,
    parameter int K     = LHR_K_DEFAULT,
    parameter int DEPTH = LHR_DEPTH_DEFAULT,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_push,
    input  logic [M-1:0]  i_push_index,
    input  logic [K-1:0]  i_push_lhr,
    input  logic          i_push_dir,
    input  logic          i_pop,
    input  logic          i_clear,
    input  logic [PW-1:0] i_rd_ptr,
    output logic [M-1:0]  o_head_index,
    output logic [K-2:0]  o_head_lhr_upper,
    output logic          o_head_dir,
    output logic [M-1:0]  o_rd_index,
    output logic [K-1:0]  o_rd_lhr,
    output logic [PW-1:0] o_head_ptr,
    output logic [PW-1:0] o_tail_ptr,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    logic [M-1:0]  r_index_mem [DEPTH];
    logic [K-1:0]  r_lhr_mem   [DEPTH];
    logic          r_dir_mem   [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [K-1:0]  w_head_lhr;

    // Storage is deliberately left unreset; validity is tracked by the pointers.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_index_mem[r_tail] <= i_push_index;
            r_lhr_mem[r_tail]   <= i_push_lhr;
            r_dir_mem[r_tail]   <= i_push_dir;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push)
                r_tail <= r_tail + PW'(1);
            if (i_pop)
                r_head <= r_head + PW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign w_head_lhr       = r_lhr_mem[r_head];
    assign o_head_index     = r_index_mem[r_head];
    assign o_head_lhr_upper = w_head_lhr[K-1:1];
    assign o_head_dir       = r_dir_mem[r_head];
    assign o_rd_index       = r_index_mem[i_rd_ptr];
    assign o_rd_lhr         = r_lhr_mem[i_rd_ptr];
    assign o_head_ptr       = r_head;
    assign o_tail_ptr       = r_tail;
    assign o_count          = r_count;
    assign o_full           = (r_count == CW'(DEPTH));
    assign o_empty          = (r_count == '0);

endmodule

// File: rtl/lhr_repair_unit.sv
// Speculative local-history checkpoint/repair: retires branches in order and,
// on a mispredict, rewrites in-flight history entries youngest-first.
module lhr_repair_unit
    import lhr_repair_unit_pkg::*;
#(
    parameter int M     = LHR_M_DEFAULT,
    parameter int K     = LHR_K_DEFAULT,
    parameter int DEPTH = LHR_DEPTH_DEFAULT,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_push_valid,
    input  logic [M-1:0]  i_push_index,
    input  logic [K-1:0]  i_push_lhr,
    input  logic          i_push_pred_dir,
    input  logic          i_resolve_valid,
    input  logic          i_resolve_taken,
    output logic          o_repair_we,
    output logic [M-1:0]  o_repair_index,
    output logic [K-1:0]  o_repair_lhr,
    output logic          o_repair_busy,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_overflow,
    output logic [CW-1:0] o_count
);

    repair_state_t r_state;
    repair_state_t w_state_next;

    logic [PW-1:0] r_walk_ptr;
    logic [PW-1:0] w_walk_ptr_next;
    logic [M-1:0]  r_fix_index;
    logic [K-1:0]  r_fix_lhr;
    logic [M-1:0]  w_fix_index_next;
    logic [K-1:0]  w_fix_lhr_next;
    logic          r_overflow;
    logic          r_repair_we;
    logic [M-1:0]  r_repair_index;
    logic [K-1:0]  r_repair_lhr;
    logic          w_repair_we_next;
    logic [M-1:0]  w_repair_index_next;
    logic [K-1:0]  w_repair_lhr_next;

    logic          w_idle;
    logic          w_resolve;
    logic          w_mispredict;
    logic          w_pop;
    logic          w_push_req;
    logic          w_push;
    logic          w_drop;
    logic          w_clear;

    logic [M-1:0]  w_head_index;
    logic [K-2:0]  w_head_lhr_upper;
    logic          w_head_dir;
    logic [M-1:0]  w_rd_index;
    logic [K-1:0]  w_rd_lhr;
    logic [PW-1:0] w_head_ptr;
    logic [PW-1:0] w_tail_ptr;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;

    lhr_ckpt_fifo #(
        .M     (M),
        .K     (K),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_push           (w_push),
        .i_push_index     (i_push_index),
        .i_push_lhr       (i_push_lhr),
        .i_push_dir       (i_push_pred_dir),
        .i_pop            (w_pop),
        .i_clear          (w_clear),
        .i_rd_ptr         (w_walk_ptr_next),
        .o_head_index     (w_head_index),
        .o_head_lhr_upper (w_head_lhr_upper),
        .o_head_dir       (w_head_dir),
        .o_rd_index       (w_rd_index),
        .o_rd_lhr         (w_rd_lhr),
        .o_head_ptr       (w_head_ptr),
        .o_tail_ptr       (w_tail_ptr),
        .o_count          (w_count),
        .o_full           (w_full),
        .o_empty          (w_empty)
    );

    // A mispredicting resolve kills any same-cycle push: that branch is younger.
    assign w_idle       = (r_state == ST_IDLE);
    assign w_resolve    = w_idle && i_resolve_valid && !w_empty;
    assign w_mispredict = w_resolve && (i_resolve_taken != w_head_dir);
    assign w_pop        = w_resolve && !w_mispredict;
    assign w_push_req   = w_idle && i_push_valid && !w_mispredict;
    assign w_push       = w_push_req && (!w_full || w_pop);
    assign w_drop       = w_push_req && w_full && !w_pop;
    assign w_clear      = (r_state == ST_FIX);

    assign w_fix_index_next = w_idle ? w_head_index : r_fix_index;
    assign w_fix_lhr_next   = w_idle ? {i_resolve_taken, w_head_lhr_upper} : r_fix_lhr;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_walk_ptr  <= '0;
            r_fix_index <= '0;
            r_fix_lhr   <= '0;
        end else begin
            r_state     <= w_state_next;
            r_walk_ptr  <= w_walk_ptr_next;
            r_fix_index <= w_fix_index_next;
            r_fix_lhr   <= w_fix_lhr_next;
        end
    end

    // Walk stops once the entry just above head is written; head itself is the fix.
    always_comb begin
        w_state_next    = r_state;
        w_walk_ptr_next = r_walk_ptr;
        case (r_state)
            ST_IDLE: begin
                w_walk_ptr_next = w_tail_ptr - PW'(1);
                if (w_mispredict)
                    w_state_next = (w_count > CW'(1)) ? ST_WALK : ST_FIX;
            end
            ST_WALK: begin
                w_walk_ptr_next = r_walk_ptr - PW'(1);
                if (r_walk_ptr == (w_head_ptr + PW'(1)))
                    w_state_next = ST_FIX;
            end
            ST_FIX: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_repair_we_next    = 1'b0;
        w_repair_index_next = '0;
        w_repair_lhr_next   = '0;
        case (w_state_next)
            ST_WALK: begin
                w_repair_we_next    = 1'b1;
                w_repair_index_next = w_rd_index;
                w_repair_lhr_next   = w_rd_lhr;
            end
            ST_FIX: begin
                w_repair_we_next    = 1'b1;
                w_repair_index_next = w_fix_index_next;
                w_repair_lhr_next   = w_fix_lhr_next;
            end
            default: begin
                w_repair_we_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_repair_we    <= 1'b0;
            r_repair_index <= '0;
            r_repair_lhr   <= '0;
            r_overflow     <= 1'b0;
        end else begin
            r_repair_we    <= w_repair_we_next;
            r_repair_index <= w_repair_index_next;
            r_repair_lhr   <= w_repair_lhr_next;
            if (w_drop)
                r_overflow <= 1'b1;
        end
    end

    assign o_repair_we    = r_repair_we;
    assign o_repair_index = r_repair_index;
    assign o_repair_lhr   = r_repair_lhr;
    assign o_repair_busy  = (r_state != ST_IDLE);
    assign o_full         = w_full;
    assign o_empty        = w_empty;
    assign o_overflow     = r_overflow;
    assign o_count        = w_count;

endmodule

// File: tb/tb_lhr_repair_unit.sv
// Directed bench for the local-history repair unit: push/retire, single and
// multi-entry repairs, overflow with wrap, discard rules, reset mid-walk.
module tb_lhr_repair_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       push_valid = 1'b0;
    logic [5:0] push_index = '0;
    logic [9:0] push_lhr = '0;
    logic       push_pred_dir = 1'b0;
    logic       resolve_valid = 1'b0;
    logic       resolve_taken = 1'b0;
    logic       repair_we;
    logic [5:0] repair_index;
    logic [9:0] repair_lhr;
    logic       repair_busy;
    logic       full;
    logic       empty;
    logic       overflow;
    logic [3:0] count;

    int total = 0;
    int bad = 0;

    lhr_repair_unit #(.M(6), .K(10), .DEPTH(8)) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_push_valid    (push_valid),
        .i_push_index    (push_index),
        .i_push_lhr      (push_lhr),
        .i_push_pred_dir (push_pred_dir),
        .i_resolve_valid (resolve_valid),
        .i_resolve_taken (resolve_taken),
        .o_repair_we     (repair_we),
        .o_repair_index  (repair_index),
        .o_repair_lhr    (repair_lhr),
        .o_repair_busy   (repair_busy),
        .o_full          (full),
        .o_empty         (empty),
        .o_overflow      (overflow),
        .o_count         (count)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_push(input logic [5:0] idx, input logic [9:0] lhr, input logic dir);
        push_valid    = 1'b1;
        push_index    = idx;
        push_lhr      = lhr;
        push_pred_dir = dir;
        $display("push idx=%0d lhr=0x%03h pred=%0b", idx, lhr, dir);
    endtask

    task automatic set_resolve(input logic taken);
        resolve_valid = 1'b1;
        resolve_taken = taken;
        $display("resolve taken=%0b", taken);
    endtask

    task automatic clear_inputs;
        push_valid    = 1'b0;
        resolve_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b want=1", empty); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b want=0", full); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0b want=0", overflow); end
        total++; if (repair_we !== 1'b0 || repair_busy !== 1'b0) begin bad++; $display("FAIL reset_repair got we=%0b busy=%0b want 0/0", repair_we, repair_busy); end
    endtask

    task automatic test_correct;
        set_push(6'd5, 10'h155, 1'b1);
        step();
        clear_inputs();
        total++; if (count !== 4'd1 || empty !== 1'b0) begin bad++; $display("FAIL correct_push got count=%0d empty=%0b want 1/0", count, empty); end
        set_resolve(1'b1);
        step();
        clear_inputs();
        total++; if (count !== 4'd0 || empty !== 1'b1) begin bad++; $display("FAIL correct_retire got count=%0d empty=%0b want 0/1", count, empty); end
        total++; if (repair_we !== 1'b0 || repair_busy !== 1'b0) begin bad++; $display("FAIL correct_norepair got we=%0b busy=%0b want 0/0", repair_we, repair_busy); end
    endtask

    task automatic test_single_mispredict;
        set_push(6'd3, 10'h0F0, 1'b1);
        step();
        clear_inputs();
        set_resolve(1'b0);
        step();
        clear_inputs();
        total++; if (repair_we !== 1'b1 || repair_busy !== 1'b1) begin bad++; $display("FAIL single_we got we=%0b busy=%0b want 1/1", repair_we, repair_busy); end
        total++; if (repair_index !== 6'd3 || repair_lhr !== 10'h078) begin bad++; $display("FAIL single_data got idx=%0d lhr=0x%03h want 3/0x078", repair_index, repair_lhr); end
        step();
        total++; if (repair_we !== 1'b0 || repair_busy !== 1'b0 || count !== 4'd0) begin bad++; $display("FAIL single_done got we=%0b busy=%0b count=%0d want 0/0/0", repair_we, repair_busy, count); end
    endtask

    task automatic test_walk;
        logic [5:0] exp_idx [3];
        logic [9:0] exp_lhr [3];
        exp_idx[0] = 6'd2; exp_lhr[0] = 10'h003;
        exp_idx[1] = 6'd7; exp_lhr[1] = 10'h002;
        exp_idx[2] = 6'd2; exp_lhr[2] = 10'h000;
        set_push(6'd2, 10'h001, 1'b1); step();
        set_push(6'd7, 10'h002, 1'b0); step();
        set_push(6'd2, 10'h003, 1'b1); step();
        clear_inputs();
        total++; if (count !== 4'd3) begin bad++; $display("FAIL walk_fill got count=%0d want 3", count); end
        set_resolve(1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            clear_inputs();
            total++;
            if (repair_we !== 1'b1 || repair_busy !== 1'b1 || repair_index !== exp_idx[i] || repair_lhr !== exp_lhr[i]) begin
                bad++;
                $display("FAIL walk_write%0d got we=%0b busy=%0b idx=%0d lhr=0x%03h want 1/1/%0d/0x%03h",
                         i, repair_we, repair_busy, repair_index, repair_lhr, exp_idx[i], exp_lhr[i]);
            end
        end
        step();
        total++; if (repair_we !== 1'b0 || repair_busy !== 1'b0 || count !== 4'd0) begin bad++; $display("FAIL walk_done got we=%0b busy=%0b count=%0d want 0/0/0", repair_we, repair_busy, count); end
    endtask

    task automatic test_overflow;
        logic [5:0] e_idx;
        logic [9:0] e_lhr;
        for (int i = 0; i < 8; i++) begin
            set_push(6'(i), 10'h100 + 10'(i), 1'b1);
            step();
        end
        clear_inputs();
        total++; if (full !== 1'b1 || count !== 4'd8 || overflow !== 1'b0) begin bad++; $display("FAIL ovf_fill got full=%0b count=%0d ovf=%0b want 1/8/0", full, count, overflow); end
        set_push(6'd20, 10'h3AA, 1'b1);
        step();
        clear_inputs();
        total++; if (overflow !== 1'b1 || count !== 4'd8) begin bad++; $display("FAIL ovf_drop got ovf=%0b count=%0d want 1/8", overflow, count); end
        set_push(6'd9, 10'h109, 1'b1);
        set_resolve(1'b1);
        step();
        clear_inputs();
        total++; if (count !== 4'd8 || full !== 1'b1 || overflow !== 1'b1) begin bad++; $display("FAIL ovf_pushpop got count=%0d full=%0b ovf=%0b want 8/1/1", count, full, overflow); end
        // Head is now entry idx 1; the youngest write exposes where tail wrapped.
        set_resolve(1'b0);
        for (int i = 0; i < 8; i++) begin
            step();
            clear_inputs();
            if (i == 0) begin e_idx = 6'd9; e_lhr = 10'h109; end
            else if (i == 7) begin e_idx = 6'd1; e_lhr = 10'h080; end
            else begin e_idx = 6'(8 - i); e_lhr = 10'h100 + 10'(8 - i); end
            total++;
            if (repair_we !== 1'b1 || repair_busy !== 1'b1 || repair_index !== e_idx || repair_lhr !== e_lhr) begin
                bad++;
                $display("FAIL ovf_walk%0d got we=%0b busy=%0b idx=%0d lhr=0x%03h want 1/1/%0d/0x%03h",
                         i, repair_we, repair_busy, repair_index, repair_lhr, e_idx, e_lhr);
            end
        end
        step();
        total++; if (repair_busy !== 1'b0 || count !== 4'd0 || overflow !== 1'b1) begin bad++; $display("FAIL ovf_done got busy=%0b count=%0d ovf=%0b want 0/0/1", repair_busy, count, overflow); end
    endtask

    task automatic test_empty_and_discard;
        set_resolve(1'b0);
        step();
        clear_inputs();
        total++; if (repair_we !== 1'b0 || repair_busy !== 1'b0 || count !== 4'd0 || empty !== 1'b1) begin bad++; $display("FAIL empty_resolve got we=%0b busy=%0b count=%0d empty=%0b want 0/0/0/1", repair_we, repair_busy, count, empty); end
        set_push(6'd6, 10'h010, 1'b0);
        step();
        set_push(6'd4, 10'h3FF, 1'b1);
        set_resolve(1'b1);
        step();
        clear_inputs();
        total++; if (repair_we !== 1'b1 || repair_busy !== 1'b1 || repair_index !== 6'd6 || repair_lhr !== 10'h208) begin bad++; $display("FAIL discard_fix got we=%0b busy=%0b idx=%0d lhr=0x%03h want 1/1/6/0x208", repair_we, repair_busy, repair_index, repair_lhr); end
        step();
        total++; if (repair_we !== 1'b0 || count !== 4'd0 || empty !== 1'b1) begin bad++; $display("FAIL discard_done got we=%0b count=%0d empty=%0b want 0/0/1", repair_we, count, empty); end
    endtask

    task automatic test_reset_mid_walk;
        for (int i = 0; i < 4; i++) begin
            set_push(6'(10 + i), 10'h040 + 10'(i), 1'b1);
            step();
        end
        clear_inputs();
        set_resolve(1'b0);
        step();
        clear_inputs();
        step();
        total++; if (repair_we !== 1'b1 || repair_busy !== 1'b1) begin bad++; $display("FAIL midwalk_active got we=%0b busy=%0b want 1/1", repair_we, repair_busy); end
        #2;
        reset = 1'b1;
        $display("reset asserted mid-walk");
        #1;
        total++; if (repair_we !== 1'b0 || repair_busy !== 1'b0) begin bad++; $display("FAIL midwalk_abort got we=%0b busy=%0b want 0/0", repair_we, repair_busy); end
        total++; if (count !== 4'd0 || overflow !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL midwalk_state got count=%0d ovf=%0b empty=%0b want 0/0/1", count, overflow, empty); end
        step();
        reset = 1'b0;
        step();
        total++; if (repair_we !== 1'b0 || repair_busy !== 1'b0) begin bad++; $display("FAIL midwalk_after got we=%0b busy=%0b want 0/0", repair_we, repair_busy); end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_single_mispredict();
        test_walk();
        test_overflow();
        test_empty_and_discard();
        test_reset_mid_walk();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
